// File: rtl/dmem_arbiter_if.sv
// Purpose: bundle of the CPU, host and data-memory signals around dmem_arbiter.
// Ports (slave = arbiter side):
//   CPU  : c_req/c_we/c_word/c_addr/c_wdata in, c_gnt/c_rvalid/c_rdata out
//   Host : h_req/h_we/h_addr/h_wdata in,        h_gnt/h_rvalid/h_rdata out
//   Mem  : m_rdata in, m_en/m_we/m_addr/m_wdata out
//   busy : out, high whenever the sequencer is not idle
// The master modport is the requester/memory side (used by the testbench).
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8
);
  logic          c_req;
  logic          c_we;
  logic          c_word;
  logic [AW-1:0] c_addr;
  logic [15:0]   c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [15:0]   c_rdata;

  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [7:0]    h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [7:0]    h_rdata;

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;
  logic [7:0]    m_rdata;

  logic          busy;

  modport slave (
    input  c_req, c_we, c_word, c_addr, c_wdata,
    input  h_req, h_we, h_addr, h_wdata,
    input  m_rdata,
    output c_gnt, c_rvalid, c_rdata,
    output h_gnt, h_rvalid, h_rdata,
    output m_en, m_we, m_addr, m_wdata,
    output busy
  );

  modport master (
    output c_req, c_we, c_word, c_addr, c_wdata,
    output h_req, h_we, h_addr, h_wdata,
    output m_rdata,
    input  c_gnt, c_rvalid, c_rdata,
    input  h_gnt, h_rvalid, h_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: two-port arbiter/sequencer for the byte-wide data memory. Shares
// the memory between the CPU load/store path and the host loader; CPU word
// accesses are split into two little-endian byte beats (low byte first).
// Ports:
//   i_clk : clock, rising edge
//   i_rst : asynchronous active-high reset, returns to IDLE
//   bus   : dmem_arbiter_if.slave (CPU, host and memory signal groups)
module dmem_arbiter #(
  parameter int unsigned AW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_B0   = 2'd1;
  localparam logic [1:0] S_B1   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic          w_pick_cpu;
  logic          w_accept;

  logic          r_last_cpu;   // 1: CPU served last, 0: host served last
  logic          r_sel_cpu;    // owner of the transaction in flight
  logic          r_we;
  logic          r_word;
  logic [AW-1:0] r_addr;
  logic [15:0]   r_wdata;
  logic [7:0]    r_lo_byte;
  logic [15:0]   r_c_rdata;
  logic [7:0]    r_h_rdata;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and decoded outputs
  always_comb begin
    w_next       = r_state;
    w_accept     = (r_state == S_IDLE) && (bus.c_req || bus.h_req);
    // On a tie the requester not served last wins
    w_pick_cpu   = bus.c_req && (!bus.h_req || !r_last_cpu);
    bus.c_gnt    = 1'b0;
    bus.h_gnt    = 1'b0;
    bus.c_rvalid = 1'b0;
    bus.h_rvalid = 1'b0;
    bus.c_rdata  = r_c_rdata;
    bus.h_rdata  = r_h_rdata;
    bus.m_en     = 1'b0;
    bus.m_we     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wdata  = 8'h00;
    bus.busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_B0;
      end
      S_B0: begin
        bus.c_gnt   = r_sel_cpu;
        bus.h_gnt   = !r_sel_cpu;
        bus.m_en    = 1'b1;
        bus.m_we    = r_we;
        bus.m_addr  = r_addr;
        bus.m_wdata = r_wdata[7:0];
        w_next      = r_word ? S_B1 : S_DONE;
      end
      S_B1: begin
        bus.m_en    = 1'b1;
        bus.m_we    = r_we;
        bus.m_addr  = r_addr + AW'(1);  // wraps modulo 2^AW
        bus.m_wdata = r_wdata[15:8];
        w_next      = S_DONE;
      end
      S_DONE: begin
        // Last read beat is on m_rdata this cycle; forward it with rvalid
        if (!r_we) begin
          if (r_sel_cpu) begin
            bus.c_rvalid = 1'b1;
            bus.c_rdata  = r_word ? {bus.m_rdata, r_lo_byte} : {8'h00, bus.m_rdata};
          end else begin
            bus.h_rvalid = 1'b1;
            bus.h_rdata  = bus.m_rdata;
          end
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, arbitration history and read-data holding registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_cpu <= 1'b0;
      r_sel_cpu  <= 1'b0;
      r_we       <= 1'b0;
      r_word     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 16'h0000;
      r_lo_byte  <= 8'h00;
      r_c_rdata  <= 16'h0000;
      r_h_rdata  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_sel_cpu  <= w_pick_cpu;
        r_last_cpu <= w_pick_cpu;
        r_we       <= w_pick_cpu ? bus.c_we : bus.h_we;
        r_word     <= w_pick_cpu && bus.c_word;
        r_addr     <= w_pick_cpu ? bus.c_addr : bus.h_addr;
        r_wdata    <= w_pick_cpu ? bus.c_wdata : {8'h00, bus.h_wdata};
      end
      if (r_state == S_B1) r_lo_byte <= bus.m_rdata;
      if (bus.c_rvalid)    r_c_rdata <= bus.c_rdata;
      if (bus.h_rvalid)    r_h_rdata <= bus.h_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors against a byte-wide synchronous
// memory model, outputs sampled on the falling clock edge.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  dmem_arbiter_if #(.AW(AW)) bus ();

  dmem_arbiter #(.AW(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: preset to addr ^ C3 on the first edge, 1-cycle read latency
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hC3;
      mem_ready <= 1'b1;
    end else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata     <= mem[bus.m_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_word = 1'b0;
    bus.c_addr = '0;  bus.c_wdata = 16'h0000;
    bus.h_req = 1'b0; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = 8'h00;
  endtask

  // One complete access; called on a falling edge while the DUT is idle.
  task automatic do_op(input bit cpu, input bit we, input bit word,
                       input logic [7:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_rd, input string tag);
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  a1;
    lo = wdata[7:0];
    hi = wdata[15:8];
    a1 = addr + 8'd1;
    if (cpu) begin
      bus.c_req = 1'b1; bus.c_we = we; bus.c_word = word;
      bus.c_addr = addr; bus.c_wdata = wdata;
    end else begin
      bus.h_req = 1'b1; bus.h_we = we; bus.h_addr = addr; bus.h_wdata = lo;
    end
    @(negedge clk);  // B0
    check({tag, " b0 gnt"}, {30'd0, bus.c_gnt, bus.h_gnt}, {30'd0, cpu, !cpu});
    check({tag, " b0 mem"}, {bus.m_en, bus.m_we, 6'd0, bus.m_addr, 8'd0, bus.m_wdata},
          {1'b1, we, 6'd0, addr, 8'd0, lo});
    idle_inputs();
    if (word) begin
      @(negedge clk);  // B1
      check({tag, " b1 mem"}, {bus.m_en, bus.m_we, bus.c_gnt, 5'd0, bus.m_addr, 8'd0, bus.m_wdata},
            {1'b1, we, 1'b0, 5'd0, a1, 8'd0, hi});
    end
    @(negedge clk);  // DONE
    check({tag, " done"}, {29'd0, bus.m_en, bus.c_rvalid, bus.h_rvalid},
          {29'd0, 1'b0, cpu && !we, !cpu && !we});
    if (!we) begin
      if (cpu) check({tag, " c_rdata"}, {16'd0, bus.c_rdata}, {16'd0, exp_rd});
      else     check({tag, " h_rdata"}, {24'd0, bus.h_rdata}, {24'd0, exp_rd[7:0]});
    end
    @(negedge clk);  // IDLE
    check({tag, " idle"}, {30'd0, bus.busy, bus.m_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset outs", {25'd0, bus.c_gnt, bus.c_rvalid, bus.h_gnt, bus.h_rvalid,
                         bus.m_en, bus.m_we, bus.busy}, 32'd0);
    check("reset data", {bus.c_rdata, bus.h_rdata, bus.m_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Host byte write then read
    do_op(1'b0, 1'b1, 1'b0, 8'h10, 16'h00A5, 16'h0000, "hwr");
    check("mem 10", {24'd0, mem[8'h10]}, 32'h0000_00A5);
    do_op(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, "hrd");

    // CPU word write and read
    do_op(1'b1, 1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, "cww");
    check("mem 20/21", {16'd0, mem[8'h21], mem[8'h20]}, 32'h0000_BEEF);
    do_op(1'b1, 1'b0, 1'b1, 8'h20, 16'h0000, 16'hBEEF, "cwr");

    // Word at address wrap
    do_op(1'b1, 1'b1, 1'b1, 8'hFF, 16'h1234, 16'h0000, "wrapw");
    check("mem ff/00", {16'd0, mem[8'h00], mem[8'hFF]}, 32'h0000_1234);
    do_op(1'b1, 1'b0, 1'b1, 8'hFF, 16'h0000, 16'h1234, "wrapr");

    // CPU byte read; host read data must still hold
    do_op(1'b1, 1'b0, 1'b0, 8'h10, 16'h0000, 16'h00A5, "cbr");
    check("h_rdata hold", {24'd0, bus.h_rdata}, 32'h0000_00A5);

    // Both requests held high from reset: CPU, host, CPU, 3 cycles apart
    rst = 1'b1;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_word = 1'b0; bus.c_addr = 8'h20;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h21;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      int ph;
      bit host;
      @(negedge clk);
      ph   = i % 3;
      host = ((i / 3) % 2) == 1;
      check($sformatf("tie cyc%0d ctl", i),
            {28'd0, bus.c_gnt, bus.h_gnt, bus.m_en, bus.busy},
            {28'd0, ph == 0 && !host, ph == 0 && host, ph == 0, ph != 2});
      check($sformatf("tie cyc%0d rv", i), {30'd0, bus.c_rvalid, bus.h_rvalid},
            {30'd0, ph == 1 && !host, ph == 1 && host});
      if (ph == 1 && !host) check("tie c_rdata", {16'd0, bus.c_rdata}, 32'h0000_00EF);
      if (ph == 1 && host)  check("tie h_rdata", {24'd0, bus.h_rdata}, 32'h0000_00BE);
    end
    idle_inputs();
    @(negedge clk);
    check("tie end idle", {31'd0, bus.busy}, 32'd0);

    // Reset during B1 of a CPU word write
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_word = 1'b1;
    bus.c_addr = 8'h40; bus.c_wdata = 16'h5566;
    @(negedge clk);
    check("rst b0 gnt", {31'd0, bus.c_gnt}, 32'd1);
    idle_inputs();
    @(negedge clk);
    check("rst b1 addr", {23'd0, bus.m_en, bus.m_addr}, 32'h0000_0141);
    rst = 1'b1;
    #1;
    check("rst abort outs", {25'd0, bus.c_gnt, bus.c_rvalid, bus.h_gnt, bus.h_rvalid,
                             bus.m_en, bus.m_we, bus.busy}, 32'd0);
    check("rst abort data", {bus.c_rdata, bus.h_rdata, bus.m_addr}, 32'd0);
    check("rst abort wdata", {24'd0, bus.m_wdata}, 32'd0);
    @(negedge clk);
    check("rst no rvalid", {30'd0, bus.c_rvalid, bus.m_en}, 32'd0);
    rst = 1'b0;
    check("mem 40/41", {16'd0, mem[8'h41], mem[8'h40]}, 32'h0000_8266);
    @(negedge clk);
    do_op(1'b0, 1'b0, 1'b0, 8'h40, 16'h0000, 16'h0066, "post rst");

    // Host pulse while busy with a CPU word is ignored; next tie goes to host
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_word = 1'b1; bus.c_addr = 8'h20;
    @(negedge clk);  // B0
    bus.c_req = 1'b0;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h10;
    @(negedge clk);  // B1
    bus.h_req = 1'b0;
    check("wd b1 gnt", {30'd0, bus.c_gnt, bus.h_gnt}, 32'd0);
    @(negedge clk);  // DONE
    check("wd done", {16'd0, bus.c_rdata}, 32'h0000_BEEF);
    check("wd done gnt", {29'd0, bus.c_rvalid, bus.h_gnt, bus.h_rvalid}, 32'h0000_0004);
    @(negedge clk);  // IDLE
    check("wd idle", {30'd0, bus.busy, bus.h_gnt}, 32'd0);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_word = 1'b0; bus.c_addr = 8'h10;
    bus.h_req = 1'b1; bus.h_we = 1'b0; bus.h_addr = 8'h20;
    @(negedge clk);  // B0 host
    check("tie2 host", {30'd0, bus.c_gnt, bus.h_gnt}, 32'd1);
    bus.h_req = 1'b0;
    @(negedge clk);  // DONE host
    check("tie2 h_rdata", {23'd0, bus.h_rvalid, bus.h_rdata}, 32'h0000_01EF);
    @(negedge clk);  // IDLE
    @(negedge clk);  // B0 cpu
    check("tie2 cpu", {30'd0, bus.c_gnt, bus.h_gnt}, 32'd2);
    bus.c_req = 1'b0;
    @(negedge clk);  // DONE cpu
    check("tie2 c_rdata", {15'd0, bus.c_rvalid, bus.c_rdata}, 32'h0001_00A5);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the processor's byte-wide data memory. It shares the memory between the CPU load/store path and a host loader port that preloads operands and reads back results. CPU 16-bit word accesses are split into two little-endian byte beats. The block sits between the CPU's memory request signals and the DataMem array.

## Interface
- AW, 8, byte address width; addresses wrap modulo 2^AW
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; returns block to IDLE
- c_req  in  1  CPU request; held until c_gnt seen
- c_we  in  1  CPU write (1) / read (0)
- c_word  in  1  CPU 16-bit access (1) / byte access (0)
- c_addr  in  AW  CPU byte address (low byte address for word)
- c_wdata  in  16  CPU write data; byte access uses [7:0]
- c_gnt  out  1  one-cycle pulse: CPU request accepted
- c_rvalid  out  1  one-cycle pulse: c_rdata valid
- c_rdata  out  16  CPU read data
- h_req, h_we  in  1 each  host request / write; byte access only
- h_addr  in  AW  host byte address
- h_wdata  in  8  host write data
- h_gnt, h_rvalid  out  1 each  host grant / read-valid pulses
- h_rdata  out  8  host read data
- m_en, m_we  out  1 each  memory enable / write enable
- m_addr  out  AW  memory address
- m_wdata  out  8  memory write data
- m_rdata  in  8  memory read data, valid the cycle after m_en with m_we=0
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, B0, B1, DONE. Reset value: IDLE. last_srv register resets to HOST, so the CPU wins the first tie.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_srv.
  - On the grant edge, latch we, word, addr, wdata; update last_srv; go to B0.
  - No req: stay in IDLE.
- B0:
  - Granted port's gnt = 1.
  - m_en = 1, m_we = latched we, m_addr = addr, m_wdata = wdata[7:0].
  - Next state is B1 if latched word, else DONE.
- B1 (CPU word only):
  - m_en = 1, m_addr = addr+1 (AW-bit wrap: address 2^AW-1 pairs with 0), m_wdata = wdata[15:8].
  - Read byte from B0 is captured into lo_byte on this edge.
  - Next state: DONE.
- DONE:
  - Read: rvalid = 1 to the granted port.
  - Word: c_rdata = {m_rdata, lo_byte}. Byte: c_rdata = {8'h00, m_rdata}; h_rdata = m_rdata.
  - Write: no rvalid.
  - m_en = 0. Next state: IDLE.
- Requests are sampled only in IDLE. req high during gnt or later cycles of the same transaction is ignored. Requester drops req the cycle after gnt.
- Withdrawing req before gnt is legal: no transaction, last_srv unchanged.
- The losing requester keeps req high; it is granted at the next IDLE edge.
- rdata holds its last value until the next rvalid on that port.
- Reset mid-transaction:
  - All outputs go to 0 immediately; no gnt/rvalid is issued for the aborted access.
  - A B0 byte already written remains in memory; partial words are not rolled back.
- Reset values of outputs: c_gnt, c_rvalid, h_gnt, h_rvalid, m_en, m_we, busy = 0; c_rdata = 16'h0000; h_rdata = 8'h00; m_addr = 0; m_wdata = 0.

## Timing
- gnt, m_* and busy decode from the state and latched registers. rdata and lo_byte are registered.
- Byte access: req sampled at edge k; B0 in cycle k+1 (gnt, m_en); DONE in cycle k+2 (rvalid); IDLE in cycle k+3.
- Word access: B0 in k+1, B1 in k+2, DONE with rvalid in k+3, IDLE in k+4.
- Back-to-back: the next grant edge is the first IDLE edge. Byte throughput is 1 access per 3 cycles; word throughput is 1 per 4 cycles.
- With both req held high continuously, grants alternate CPU, host, CPU, ...
- At most one memory beat per cycle; m_en is never high in IDLE or DONE.

## Test plan
- Host byte write then read: h_we=1, h_addr=8'h10, h_wdata=8'hA5; then a read of 8'h10.
  - Required: h_gnt in cycle k+1; m_en/m_we/m_addr=10/m_wdata=A5 in k+1.
  - Required: read returns h_rvalid with h_rdata=8'hA5, 2 cycles after the read grant edge.
- CPU word write then word read: c_word=1, c_addr=8'h20, c_wdata=16'hBEEF.
  - Required: m_addr=20/m_wdata=EF, then m_addr=21/m_wdata=BE.
  - Required: word read gives c_rvalid with c_rdata=16'hBEEF in cycle k+3.
- Word at wrap: c_addr=8'hFF, c_wdata=16'h1234.
  - Required: writes 34 at FF and 12 at 00; word read returns 16'h1234.
- Simultaneous requests: c_req and h_req held high from reset.
  - Required: first grant to CPU, then host, then CPU.
  - Required: busy never drops for more than one cycle between transactions.
  - Required: m_en never high in DONE.
- Reset in B1 of a CPU word write to 8'h40 (data 16'h5566).
  - Required: outputs go to 0 immediately; no c_rvalid.
  - Required: afterwards memory holds 66 at 40; 41 is unchanged.
  - Required: next request is serviced normally.
- Withdrawn request: h_req pulses 1 cycle while busy with a CPU word.
  - Required: no host grant; state returns to IDLE.
  - Required: next tie goes to the host.
